// File: rtl/vga_framebuffer.sv
// vga_framebuffer: indexed-colour pixel store between a pixel-writing client
// and the vga timing core. Display reads run through a 3-stage pipeline that
// advances on pixel_enable_i: address, memory read, then palette lookup.
// A clear engine fills the writable buffer one pixel per cycle.
// Optional feature macro VGA_FB_DOUBLE_BUFFER_EN adds a second bank with a
// frame-synchronous swap. Without it, swap_req_i is ignored and swap_done_o is 0.
// Write handshake: a write transfers on a cycle where wr_valid_i && wr_ready_o.
// wr_ready_o is high only while the clear engine is idle.
module vga_framebuffer #(
    parameter int H_ACTIVE = 800,
    parameter int V_ACTIVE = 600,
    parameter int H_OFFSET = 216,
    parameter int V_OFFSET = 27,
    parameter int CNT_W    = 11,
    parameter int BPP      = 2,
    parameter int RGB_W    = 12
) (
    input  logic             clk_i,
    input  logic             arstn_i,
    input  logic [CNT_W-1:0] hcount_i,
    input  logic [CNT_W-1:0] vcount_i,
    input  logic             pixel_enable_i,
    output logic [RGB_W-1:0] rgb_o,
    output logic             rgb_valid_o,
    input  logic             wr_valid_i,
    output logic             wr_ready_o,
    input  logic [CNT_W-1:0] wr_x_i,
    input  logic [CNT_W-1:0] wr_y_i,
    input  logic [BPP-1:0]   wr_color_i,
    output logic             wr_oob_o,
    input  logic             pal_we_i,
    input  logic [BPP-1:0]   pal_idx_i,
    input  logic [RGB_W-1:0] pal_data_i,
    input  logic             clear_req_i,
    input  logic [BPP-1:0]   clear_color_i,
    output logic             clear_busy_o,
    output logic             clear_done_o,
    input  logic             swap_req_i,
    output logic             swap_done_o
);

    localparam int DEPTH = H_ACTIVE * V_ACTIVE;
`ifdef VGA_FB_DOUBLE_BUFFER_EN
    localparam int NBANK = 2;
`else
    localparam int NBANK = 1;
`endif
    localparam int A_W   = $clog2(DEPTH);
    localparam int M_W   = $clog2(NBANK * DEPTH);
    localparam int PAL_N = 2 ** BPP;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_CLEAR = 1'b1;

    logic [0:0]       state;
    logic [A_W-1:0]   clr_addr;
    logic [BPP-1:0]   clr_color;
    logic             last_clr;

    logic [BPP-1:0]   mem [0:NBANK*DEPTH-1];
    logic [RGB_W-1:0] pal [0:PAL_N-1];

    logic             front_sel;
    logic             back_sel;
    logic [M_W-1:0]   front_base;
    logic [M_W-1:0]   back_base;

    logic             wr_accept;
    logic             wr_in_range;
    logic             mem_we;
    logic [M_W-1:0]   mem_waddr;
    logic [BPP-1:0]   mem_wdata;

    logic [CNT_W-1:0] px;
    logic [CNT_W-1:0] py;
    logic             vis;
    logic [M_W-1:0]   rd_addr_next;
    logic [M_W-1:0]   rd_addr_s1;
    logic             vis_s1;
    logic [BPP-1:0]   idx_s2;
    logic             vis_s2;

    function automatic logic [RGB_W-1:0] pal_reset(input int i);
        case (i)
            1:       pal_reset = RGB_W'(12'hFFF);
            2:       pal_reset = RGB_W'(12'hF00);
            3:       pal_reset = RGB_W'(12'h0F0);
            default: pal_reset = '0;
        endcase
    endfunction

    assign front_base = front_sel ? M_W'(DEPTH) : '0;
    assign back_base  = back_sel  ? M_W'(DEPTH) : '0;

    // Handshake, clear status and the single memory write port (clear has priority).
    always_comb begin
        wr_ready_o   = (state == ST_IDLE);
        clear_busy_o = (state == ST_CLEAR);
        last_clr     = (state == ST_CLEAR) && (clr_addr == A_W'(DEPTH - 1));
        clear_done_o = last_clr;
        wr_accept    = wr_valid_i && wr_ready_o;
        wr_in_range  = (wr_x_i < CNT_W'(H_ACTIVE)) && (wr_y_i < CNT_W'(V_ACTIVE));
        mem_we       = 1'b0;
        mem_waddr    = '0;
        mem_wdata    = '0;
        if (state == ST_CLEAR) begin
            mem_we    = 1'b1;
            mem_waddr = back_base + M_W'(clr_addr);
            mem_wdata = clr_color;
        end else if (wr_accept && wr_in_range) begin
            mem_we    = 1'b1;
            mem_waddr = back_base + M_W'(A_W'(wr_y_i) * A_W'(H_ACTIVE) + A_W'(wr_x_i));
            mem_wdata = wr_color_i;
        end
    end

    // Stage-1 address: counters relative to the visible origin; underflow wraps large and is invisible.
    always_comb begin
        px           = hcount_i - CNT_W'(H_OFFSET);
        py           = vcount_i - CNT_W'(V_OFFSET);
        vis          = (px < CNT_W'(H_ACTIVE)) && (py < CNT_W'(V_ACTIVE));
        rd_addr_next = front_base;
        if (vis) begin
            rd_addr_next = front_base + M_W'(A_W'(py) * A_W'(H_ACTIVE) + A_W'(px));
        end
    end

    // Clear engine FSM: a request in IDLE latches the colour and sweeps every address once.
    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            state     <= ST_IDLE;
            clr_addr  <= '0;
            clr_color <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (clear_req_i) begin
                        state     <= ST_CLEAR;
                        clr_addr  <= '0;
                        clr_color <= clear_color_i;
                    end
                end
                ST_CLEAR: begin
                    if (last_clr) begin
                        state <= ST_IDLE;
                    end else begin
                        clr_addr <= clr_addr + A_W'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Out-of-range accepted writes are dropped and flagged one cycle later.
    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            wr_oob_o <= 1'b0;
        end else begin
            wr_oob_o <= wr_accept && !wr_in_range;
        end
    end

    // Pixel memory write port; contents are deliberately not reset.
    always_ff @(posedge clk_i) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    // Palette: reset to the default colours, writable at any time.
    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            for (int i = 0; i < PAL_N; i++) begin
                pal[i] <= pal_reset(i);
            end
        end else if (pal_we_i) begin
            pal[pal_idx_i] <= pal_data_i;
        end
    end

    // Display pipeline: address -> memory read -> palette lookup, frozen when pixel_enable_i is low.
    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            rd_addr_s1  <= '0;
            vis_s1      <= 1'b0;
            idx_s2      <= '0;
            vis_s2      <= 1'b0;
            rgb_o       <= '0;
            rgb_valid_o <= 1'b0;
        end else if (pixel_enable_i) begin
            rd_addr_s1  <= rd_addr_next;
            vis_s1      <= vis;
            idx_s2      <= mem[rd_addr_s1];
            vis_s2      <= vis_s1;
            rgb_o       <= vis_s2 ? pal[idx_s2] : '0;
            rgb_valid_o <= vis_s2;
        end
    end

`ifdef VGA_FB_DOUBLE_BUFFER_EN
    logic swap_pending;
    logic swap_fire;

    assign swap_fire = pixel_enable_i && (hcount_i == '0) && (vcount_i == '0) &&
                       swap_pending && (state == ST_IDLE);
    assign back_sel  = ~front_sel;

    // Sticky swap request, honoured at the first enabled frame origin once no clear is running.
    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            front_sel    <= 1'b0;
            swap_pending <= 1'b0;
            swap_done_o  <= 1'b0;
        end else begin
            swap_done_o  <= swap_fire;
            swap_pending <= swap_req_i || (swap_pending && !swap_fire);
            if (swap_fire) begin
                front_sel <= ~front_sel;
            end
        end
    end
`else
    logic swap_unused;

    assign front_sel   = 1'b0;
    assign back_sel    = 1'b0;
    assign swap_done_o = 1'b0;
    assign swap_unused = swap_req_i;
`endif

endmodule

// File: tb/tb_vga_framebuffer.sv
// Bench for vga_framebuffer on a small raster (20x10 visible inside 28x14).
// Reference model: pixel/palette arrays plus a queue of pending display samples.
`timescale 1ns/1ps
module tb_vga_framebuffer;
    localparam int H_ACTIVE = 20;
    localparam int V_ACTIVE = 10;
    localparam int H_OFFSET = 4;
    localparam int V_OFFSET = 2;
    localparam int CNT_W    = 11;
    localparam int BPP      = 2;
    localparam int RGB_W    = 12;
    localparam int H_TOTAL  = 28;
    localparam int V_TOTAL  = 14;
    localparam int FRAME    = H_TOTAL * V_TOTAL;
    localparam int DEPTH    = H_ACTIVE * V_ACTIVE;
`ifdef VGA_FB_DOUBLE_BUFFER_EN
    localparam bit DB = 1'b1;
`else
    localparam bit DB = 1'b0;
`endif

    // ---------------- clock / reset / DUT ----------------
    logic             clk = 1'b0;
    logic             arstn_i;
    logic [CNT_W-1:0] hcount_i, vcount_i;
    logic             pixel_enable_i;
    logic [RGB_W-1:0] rgb_o;
    logic             rgb_valid_o;
    logic             wr_valid_i, wr_ready_o;
    logic [CNT_W-1:0] wr_x_i, wr_y_i;
    logic [BPP-1:0]   wr_color_i;
    logic             wr_oob_o;
    logic             pal_we_i;
    logic [BPP-1:0]   pal_idx_i;
    logic [RGB_W-1:0] pal_data_i;
    logic             clear_req_i;
    logic [BPP-1:0]   clear_color_i;
    logic             clear_busy_o, clear_done_o;
    logic             swap_req_i, swap_done_o;

    always #5 clk = ~clk;

    vga_framebuffer #(
        .H_ACTIVE(H_ACTIVE), .V_ACTIVE(V_ACTIVE), .H_OFFSET(H_OFFSET), .V_OFFSET(V_OFFSET),
        .CNT_W(CNT_W), .BPP(BPP), .RGB_W(RGB_W)
    ) dut (
        .clk_i(clk), .arstn_i(arstn_i),
        .hcount_i(hcount_i), .vcount_i(vcount_i), .pixel_enable_i(pixel_enable_i),
        .rgb_o(rgb_o), .rgb_valid_o(rgb_valid_o),
        .wr_valid_i(wr_valid_i), .wr_ready_o(wr_ready_o),
        .wr_x_i(wr_x_i), .wr_y_i(wr_y_i), .wr_color_i(wr_color_i), .wr_oob_o(wr_oob_o),
        .pal_we_i(pal_we_i), .pal_idx_i(pal_idx_i), .pal_data_i(pal_data_i),
        .clear_req_i(clear_req_i), .clear_color_i(clear_color_i),
        .clear_busy_o(clear_busy_o), .clear_done_o(clear_done_o),
        .swap_req_i(swap_req_i), .swap_done_o(swap_done_o)
    );

    // ---------------- reference model state ----------------
    typedef struct { bit chk; bit vis; int bank; int addr; } pix_t;
    typedef struct { int x; int y; int color; bit oob; } wr_vec_t;

    pix_t exp_q[$];
    int   m_mem [0:2*DEPTH-1];
    int   m_pal [0:3];
    int   m_front, m_clr_left, m_clr_color;
    bit   m_pending, m_oob, m_swap_done;

    int   checks = 0, errors = 0, cycles = 0;
    int   hc = 0, vc = 0, en_mode = 0;
    bit   chk_en = 1'b0;
    int   vld_cnt = 0, swap_cnt = 0;

    // ---------------- scoreboard ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d, h=%0d v=%0d)",
                     name, act, exp_v, cycles, hcount_i, vcount_i);
        end
    endtask

    // ---------------- driver: one clock with model update ----------------
    task automatic step();
        bit   busy_pre, accept, fire;
        int   back_pre, vx, vy, wa;
        pix_t e, p;
        busy_pre = (m_clr_left > 0);
        back_pre = DB ? 1 - m_front : m_front;
        @(posedge clk); #1;
        cycles++;
        if (pixel_enable_i) begin
            vx = int'(hcount_i) - H_OFFSET;
            vy = int'(vcount_i) - V_OFFSET;
            e.chk  = chk_en;
            e.vis  = (vx >= 0) && (vx < H_ACTIVE) && (vy >= 0) && (vy < V_ACTIVE);
            e.bank = m_front;
            e.addr = e.vis ? vy * H_ACTIVE + vx : 0;
            exp_q.push_back(e);
            if (exp_q.size() == 3) begin
                p = exp_q.pop_front();
                if (p.chk) begin
                    check("rgb_valid", rgb_valid_o, p.vis);
                    check("rgb", rgb_o, p.vis ? m_pal[m_mem[p.bank*DEPTH + p.addr]] : 0);
                end
            end
            if (rgb_valid_o) vld_cnt++;
        end
        if (swap_done_o) swap_cnt++;
        // model reacts to the inputs sampled at this edge
        accept = wr_valid_i && !busy_pre;
        m_oob  = accept && ((int'(wr_x_i) >= H_ACTIVE) || (int'(wr_y_i) >= V_ACTIVE));
        if (accept && !m_oob) begin
            wa = back_pre*DEPTH + int'(wr_y_i)*H_ACTIVE + int'(wr_x_i);
            m_mem[wa] = int'(wr_color_i);
        end
        if (busy_pre) begin
            m_clr_left--;
            if (m_clr_left == 0)
                for (int i = 0; i < DEPTH; i++) m_mem[back_pre*DEPTH + i] = m_clr_color;
        end else if (clear_req_i) begin
            m_clr_left  = DEPTH;
            m_clr_color = int'(clear_color_i);
        end
        if (pal_we_i) m_pal[pal_idx_i] = int'(pal_data_i);
        fire = DB && pixel_enable_i && (hcount_i == 0) && (vcount_i == 0) && m_pending && !busy_pre;
        m_swap_done = fire;
        if (fire) m_front = 1 - m_front;
        m_pending = DB && (swap_req_i || (m_pending && !fire));
        check("wr_ready", wr_ready_o, m_clr_left == 0);
        check("clear_busy", clear_busy_o, m_clr_left > 0);
        check("clear_done", clear_done_o, m_clr_left == 1);
        check("wr_oob", wr_oob_o, m_oob);
        check("swap_done", swap_done_o, m_swap_done);
        // raster advance and next-cycle enable
        if (pixel_enable_i) begin
            hc++;
            if (hc == H_TOTAL) begin
                hc = 0;
                vc = (vc == V_TOTAL - 1) ? 0 : vc + 1;
            end
        end
        hcount_i = CNT_W'(hc);
        vcount_i = CNT_W'(vc);
        pixel_enable_i = (en_mode == 0) ? 1'b1 : (en_mode == 1) ? ($urandom_range(0, 3) != 0) : 1'b0;
    endtask

    task automatic run_enabled(input int n);
        int k;
        k = 0;
        for (int i = 0; i < 4*n && k < n; i++) begin
            if (pixel_enable_i) k++;
            step();
        end
    endtask

    task automatic do_reset();
        wr_valid_i = 0; pal_we_i = 0; clear_req_i = 0; swap_req_i = 0; pixel_enable_i = 0;
        arstn_i = 0;
        #2;
        m_clr_left = 0; m_oob = 0; m_swap_done = 0; m_front = 0; m_pending = 0;
        m_pal = '{0, 'hFFF, 'hF00, 'h0F0};
        exp_q.delete();
        check("rst_rgb", rgb_o, 0);
        check("rst_rgb_valid", rgb_valid_o, 0);
        check("rst_wr_ready", wr_ready_o, 1);
        check("rst_wr_oob", wr_oob_o, 0);
        check("rst_clear_busy", clear_busy_o, 0);
        check("rst_clear_done", clear_done_o, 0);
        check("rst_swap_done", swap_done_o, 0);
        repeat (2) @(negedge clk);
        arstn_i = 1;
        @(posedge clk); #1;
        pixel_enable_i = (en_mode == 0) ? 1'b1 : (en_mode == 1) ? ($urandom_range(0, 3) != 0) : 1'b0;
    endtask

    task automatic do_clear(input int color);
        clear_color_i = BPP'(color);
        clear_req_i = 1;
        step();
        clear_req_i = 0;
        wr_valid_i = 0;
        for (int i = 0; i < DEPTH + 20 && clear_busy_o; i++) step();
        check("clear_end", clear_busy_o, 0);
    endtask

    task automatic do_swap_frame();
        swap_req_i = 1;
        step();
        swap_req_i = 0;
        run_enabled(FRAME + 4);
    endtask

    // ---------------- test sequence ----------------
    wr_vec_t wr_tab [8];
    int busy_cnt, done_cnt;

    initial begin
        wr_tab[0] = '{5, 2, 2, 1'b0};
        wr_tab[1] = '{H_ACTIVE, 0, 1, 1'b1};
        wr_tab[2] = '{0, V_ACTIVE, 3, 1'b1};
        wr_tab[3] = '{H_ACTIVE-1, V_ACTIVE-1, 3, 1'b0};
        wr_tab[4] = '{0, 0, 1, 1'b0};
        wr_tab[5] = '{2047, 2047, 2, 1'b1};
        wr_tab[6] = '{6, 2, 3, 1'b0};
        wr_tab[7] = '{4, 2, 1, 1'b0};

        hcount_i = 0; vcount_i = 0; wr_x_i = 0; wr_y_i = 0; wr_color_i = 0;
        pal_idx_i = 0; pal_data_i = 0; clear_color_i = 0;
        for (int i = 0; i < 2*DEPTH; i++) m_mem[i] = 0;
        m_clr_color = 0;
        en_mode = 1;
        do_reset();

        // bring both banks to a known colour (swap is a no-op in the single-bank build)
        do_clear(1);
        do_swap_frame();

        // clear engine: exact duration, single done pulse, writes blocked, re-request ignored
        clear_color_i = 1; clear_req_i = 1;
        step();
        clear_req_i = 0;
        busy_cnt = 0; done_cnt = 0;
        wr_valid_i = 1; wr_x_i = 3; wr_y_i = 3; wr_color_i = 2;
        for (int i = 0; i < DEPTH + 20 && clear_busy_o; i++) begin
            if (i == DEPTH/2) begin clear_req_i = 1; clear_color_i = 3; end
            if (i == DEPTH/2 + 1) clear_req_i = 0;
            busy_cnt++;
            if (clear_done_o) done_cnt++;
            step();
        end
        wr_valid_i = 0;
        check("clear_busy_cycles", busy_cnt, DEPTH);
        check("clear_done_pulses", done_cnt, 1);

        // full frame after clear to index 1 -> 0xFFF, valid exactly H_ACTIVE*V_ACTIVE times
        chk_en = 1; en_mode = 0; step();
        vld_cnt = 0;
        run_enabled(FRAME);
        check("valid_per_frame", vld_cnt, DEPTH);

        // clear to 0 with a write accepted in the same cycle (clear overwrites it)
        chk_en = 0; en_mode = 1;
        wr_valid_i = 1; wr_x_i = 1; wr_y_i = 1; wr_color_i = 3;
        do_clear(0);
        chk_en = 1;
        run_enabled(FRAME);

        // table-driven writes: in-range lands in memory, out-of-range pulses wr_oob_o once
        chk_en = 0;
        foreach (wr_tab[i]) begin
            wr_x_i = CNT_W'(wr_tab[i].x); wr_y_i = CNT_W'(wr_tab[i].y);
            wr_color_i = BPP'(wr_tab[i].color); wr_valid_i = 1;
            step();
            wr_valid_i = 0;
            check("tab_oob_pulse", wr_oob_o, wr_tab[i].oob);
            step();
            check("tab_oob_after", wr_oob_o, 0);
        end
        chk_en = 1;
        run_enabled(FRAME);

        // palette change mid-frame: later idx3 pixels take the new colour
        begin
            bit done_pal;
            int k;
            done_pal = 0; k = 0;
            for (int i = 0; i < 4*FRAME && k < FRAME; i++) begin
                if (!done_pal && vc == V_OFFSET + 4 && hc == H_OFFSET) begin
                    pal_we_i = 1; pal_idx_i = 3; pal_data_i = 12'h123; done_pal = 1;
                end
                if (pixel_enable_i) k++;
                step();
                pal_we_i = 0;
            end
        end
        run_enabled(FRAME);

        // randomized writes and palette updates, then a checked frame
        for (int r = 0; r < 3; r++) begin
            chk_en = 0;
            for (int i = 0; i < 150; i++) begin
                wr_valid_i = 1'($urandom_range(0, 1));
                wr_x_i = CNT_W'($urandom_range(0, H_ACTIVE + 2));
                wr_y_i = CNT_W'($urandom_range(0, V_ACTIVE + 2));
                wr_color_i = BPP'($urandom_range(0, 3));
                pal_we_i = ($urandom_range(0, 9) == 0);
                pal_idx_i = BPP'($urandom_range(0, 3));
                pal_data_i = RGB_W'($urandom_range(0, 4095));
                step();
            end
            wr_valid_i = 0; pal_we_i = 0;
            chk_en = 1;
            run_enabled(FRAME);
        end

        // swap: display keeps the old image until the frame origin, then the back image
        chk_en = 0;
        do_clear(2);
        for (int i = 0; i < 6; i++) begin
            wr_x_i = CNT_W'(2*i); wr_y_i = CNT_W'(i); wr_color_i = 1; wr_valid_i = 1;
            step();
        end
        wr_valid_i = 0;
        chk_en = 1;
        run_enabled(3*H_TOTAL);
        swap_cnt = 0;
        do_swap_frame();
        check("swap_pulses", swap_cnt, DB ? 1 : 0);

        // reset in the middle of a clear: no done pulse, engine idle
        chk_en = 0;
        clear_color_i = 3; clear_req_i = 1;
        step();
        clear_req_i = 0;
        repeat (50) step();
        do_reset();
        step();
        check("midclr_no_done", clear_done_o, 0);
        do_clear(3);
        do_swap_frame();
        do_clear(3);
        chk_en = 1;
        run_enabled(FRAME);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #5_000_000;
        errors++;
        $display("FAIL watchdog: simulation did not complete (cycle %0d)", cycles);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule
